// File: rtl/spi_flash_loader_if.sv
// Byte stream from the SPI flash loader to the SDRAM write sequencer.
// The loader drives the byte and its index; the sequencer answers with WRready.
interface spi_flash_loader_if;
    logic [7:0]  WRD;
    logic [15:0] WRAddr;
    logic        WRvalid;
    logic        WRready;

    modport master (output WRD, output WRAddr, output WRvalid, input WRready);
    modport slave  (input WRD, input WRAddr, input WRvalid, output WRready);
endinterface

// File: rtl/spi_flash_loader.sv
// Boot-time SPI flash streamer: issues READ (0x03) + 24-bit address, then shifts
// LOAD_LEN bytes out on a valid/ready stream, stalling FCK high under backpressure.
module spi_flash_loader #(
    parameter int LOAD_LEN = 16384,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                      C25M,
    input  logic                      RES,
    input  logic                      start,
    input  logic [23:0]               BaseAddr,
    output logic                      nFCS,
    output logic                      FCK,
    output logic                      MOSI,
    input  logic                      MISO,
    spi_flash_loader_if.master        wr,
    output logic                      busy,
    output logic                      done
);

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] LAST_IDX   = 16'(LOAD_LEN - 1);
    localparam logic [7:0]  READ_CMD   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CSSETUP,
        CMD,
        DATA,
        CSHOLD,
        DONE
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;      // CS setup/hold cycle counter
    logic [31:0] cmd_q;      // command + address, shifted out MSB-first
    logic [4:0]  bit_q;      // bit index within the command or current byte
    logic        rise_q;     // next bit-cell edge raises FCK
    logic [6:0]  shift_q;    // bits 7..1 of the byte being received
    logic [15:0] idx_q;
    logic        nfcs_q;
    logic        fck_q;
    logic        mosi_q;
    logic [7:0]  wrd_q;
    logic [15:0] wraddr_q;
    logic        wrvalid_q;
    logic        busy_q;
    logic        done_q;

    // A completing byte must wait while the previous one is still unaccepted.
    logic byte_stall;
    assign byte_stall = wrvalid_q && !wr.WRready;

    // NOTE: all state below is updated with non-blocking assignments, so every
    // branch reads the pre-edge values and a later assignment to the same
    // register in this block overrides an earlier one (used for WRvalid).
    always_ff @(posedge C25M) begin
        if (RES) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            bit_q     <= '0;
            rise_q    <= 1'b0;
            shift_q   <= '0;
            idx_q     <= '0;
            nfcs_q    <= 1'b1;
            fck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            wrd_q     <= '0;
            wraddr_q  <= '0;
            wrvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (wrvalid_q && wr.WRready) begin
                wrvalid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= CSSETUP;
                        cmd_q   <= {READ_CMD, BaseAddr};
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end

                CSSETUP: begin
                    nfcs_q <= 1'b0;
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= CMD;
                        mosi_q  <= cmd_q[31];
                        cmd_q   <= {cmd_q[30:0], 1'b0};
                        bit_q   <= '0;
                        fck_q   <= 1'b0;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                CMD: begin
                    if (rise_q) begin
                        fck_q  <= 1'b1;
                        rise_q <= 1'b0;
                    end else begin
                        fck_q  <= 1'b0;
                        rise_q <= 1'b1;
                        if (bit_q == 5'd31) begin
                            state_q <= DATA;
                            mosi_q  <= 1'b0;
                            bit_q   <= '0;
                        end else begin
                            mosi_q <= cmd_q[31];
                            cmd_q  <= {cmd_q[30:0], 1'b0};
                            bit_q  <= bit_q + 5'd1;
                        end
                    end
                end

                DATA: begin
                    if (rise_q) begin
                        fck_q  <= 1'b1;
                        rise_q <= 1'b0;
                    end else if (bit_q[2:0] != 3'd7) begin
                        shift_q <= {shift_q[5:0], MISO};
                        bit_q   <= bit_q + 5'd1;
                        fck_q   <= 1'b0;
                        rise_q  <= 1'b1;
                    end else if (!byte_stall) begin
                        // Bit 0 of the byte: publish it, possibly on the same
                        // edge that retires the previous one.
                        wrd_q     <= {shift_q, MISO};
                        wraddr_q  <= idx_q;
                        wrvalid_q <= 1'b1;
                        idx_q     <= idx_q + 16'd1;
                        bit_q     <= '0;
                        fck_q     <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= CSHOLD;
                            cnt_q   <= '0;
                        end else begin
                            rise_q <= 1'b1;
                        end
                    end
                end

                CSHOLD: begin
                    if (!nfcs_q) begin
                        if (cnt_q == HOLD_LAST) begin
                            nfcs_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end else if (!wrvalid_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign nFCS       = nfcs_q;
    assign FCK        = fck_q;
    assign MOSI       = mosi_q;
    assign wr.WRD     = wrd_q;
    assign wr.WRAddr  = wraddr_q;
    assign wr.WRvalid = wrvalid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_flash_loader.sv
// Directed + randomized bench for spi_flash_loader with a behavioural SPI flash
// and a byte-level reference of what the consumer must receive and when.
module tb_spi_flash_loader;

    localparam int LEN = 4;

    typedef enum int {M_READY, M_BACKPR, M_SAME, M_RAND} rmode_t;

    logic        C25M = 1'b0;
    logic        RES;
    logic        start;
    logic [23:0] BaseAddr;
    logic        MISO = 1'b0;
    logic        nFCS, FCK, MOSI, busy, done;

    spi_flash_loader_if wr_if ();

    spi_flash_loader #(
        .LOAD_LEN (LEN),
        .CS_SETUP (2),
        .CS_HOLD  (2)
    ) dut (
        .C25M     (C25M),
        .RES      (RES),
        .start    (start),
        .BaseAddr (BaseAddr),
        .nFCS     (nFCS),
        .FCK      (FCK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .wr       (wr_if),
        .busy     (busy),
        .done     (done)
    );

    always #5 C25M = ~C25M;

    int cyc = 0;
    always @(posedge C25M) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash contents: the basic-load pattern at 0x012000, a hash elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012000: return 8'hA5;
            24'h012001: return 8'h5A;
            24'h012002: return 8'h00;
            24'h012003: return 8'hFF;
            default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h6B;
        endcase
    endfunction

    // Mode-0 SPI flash: latch MOSI on FCK rise, present next MISO bit after FCK fall.
    int          fl_bits = 0;
    int          fl_mosi_hi = 0;
    logic [31:0] fl_shift = '0;
    logic [31:0] fl_cmd_cap = '0;
    logic        fl_prev_cs = 1'b1;
    logic        fl_prev_fck = 1'b0;
    always @(FCK or nFCS) begin
        int          j;
        logic [7:0]  b;
        if (nFCS !== fl_prev_cs) begin
            fl_bits = 0;
            MISO = 1'b0;
        end else if (nFCS === 1'b0 && FCK === 1'b1 && fl_prev_fck === 1'b0) begin
            if (fl_bits < 32) fl_shift = {fl_shift[30:0], MOSI};
            else if (MOSI !== 1'b0) fl_mosi_hi++;
            fl_bits++;
            if (fl_bits == 32) fl_cmd_cap = fl_shift;
        end else if (nFCS === 1'b0 && FCK === 1'b0 && fl_prev_fck === 1'b1 && fl_bits >= 32) begin
            j = fl_bits - 32;
            b = flash_byte(fl_shift[23:0] + 24'(j / 8));
            MISO = b[7 - (j % 8)];
        end
        fl_prev_cs = nFCS;
        fl_prev_fck = FCK;
    end

    // Observations of the last load, in cycles relative to the start edge.
    int         load_rel[$];
    logic [7:0] got_d[$];
    logic [15:0] got_a[$];
    int         done_rel, ncs_fall_rel, ncs_rise_rel, first_rise_rel, fck_low_win;
    logic       busy0, done0;
    int         mosi_hi0;

    task automatic run_load(input string tag, input logic [23:0] base, input rmode_t mode,
                            input int reset_at, input int busy_start_at, input logic [23:0] alt_base);
        int          k, r, e;
        logic        pv;
        logic [15:0] pa;
        load_rel.delete(); got_d.delete(); got_a.delete();
        done_rel = -1; ncs_fall_rel = -1; ncs_rise_rel = -1; first_rise_rel = -1;
        fck_low_win = 0; busy0 = 1'b0; done0 = 1'b1; mosi_hi0 = fl_mosi_hi;
        @(negedge C25M);
        BaseAddr = base;
        start = 1'b1;
        wr_if.WRready = (mode == M_READY || mode == M_BACKPR);
        @(negedge C25M);
        start = 1'b0;
        k = cyc;
        pv = 1'b0;
        pa = '0;
        for (int n = 0; n < 3000; n++) begin
            r = cyc - k;
            if (n == 0) begin busy0 = busy; done0 = done; end
            if (wr_if.WRvalid && (!pv || wr_if.WRAddr != pa)) load_rel.push_back(r);
            if (nFCS === 1'b0 && ncs_fall_rel < 0) ncs_fall_rel = r;
            if (FCK === 1'b1 && first_rise_rel < 0) first_rise_rel = r;
            if (nFCS === 1'b1 && ncs_fall_rel >= 0 && ncs_rise_rel < 0) ncs_rise_rel = r;
            if (mode == M_BACKPR && r >= 116 && r <= 139 && FCK !== 1'b1) fck_low_win++;
            pv = wr_if.WRvalid;
            pa = wr_if.WRAddr;
            if (done === 1'b1) begin done_rel = r; break; end
            if (r == reset_at) begin RES = 1'b1; break; end
            start = (r == busy_start_at);
            if (r == busy_start_at) BaseAddr = alt_base;
            e = r + 1;
            case (mode)
                M_READY:  wr_if.WRready = 1'b1;
                M_BACKPR: wr_if.WRready = !(e >= 100 && e <= 139);
                M_SAME:   wr_if.WRready = (e >= 83 && (e - 83) % 16 == 0) || e >= 83 + 16 * LEN;
                default:  wr_if.WRready = 1'($urandom_range(1, 0));
            endcase
            if (wr_if.WRvalid && wr_if.WRready) begin
                got_d.push_back(wr_if.WRD);
                got_a.push_back(wr_if.WRAddr);
            end
            @(negedge C25M);
        end
        start = 1'b0;
        if (reset_at < 0) check({tag, " done reached"}, 64'(done_rel >= 0), 64'd1);
    endtask

    task automatic check_data(input string tag, input logic [23:0] base);
        check({tag, " byte count"}, 64'(got_d.size()), 64'(LEN));
        for (int i = 0; i < got_d.size() && i < LEN; i++) begin
            check($sformatf("%s data%0d", tag, i), 64'(got_d[i]), 64'(flash_byte(base + 24'(i))));
            check($sformatf("%s addr%0d", tag, i), 64'(got_a[i]), 64'(i));
        end
        check({tag, " cmd+addr on MOSI"}, 64'(fl_cmd_cap), 64'({8'h03, base}));
        check({tag, " MOSI low in data"}, 64'(fl_mosi_hi - mosi_hi0), 64'd0);
    endtask

    task automatic check_loads(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp_e[4];
        exp_e = '{e0, e1, e2, e3};
        check({tag, " load count"}, 64'(load_rel.size()), 64'd4);
        for (int i = 0; i < 4 && i < load_rel.size(); i++)
            check($sformatf("%s load edge%0d", tag, i), 64'(load_rel[i]), 64'(exp_e[i]));
    endtask

    task automatic check_end(input string tag, input int ncs_rise, input int done_at);
        check({tag, " nFCS rise edge"}, 64'(ncs_rise_rel), 64'(ncs_rise));
        check({tag, " done edge"}, 64'(done_rel), 64'(done_at));
        check({tag, " nFCS high at end"}, 64'(nFCS), 64'd1);
        check({tag, " busy low at end"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " nFCS"}, 64'(nFCS), 64'd1);
        check({tag, " FCK"}, 64'(FCK), 64'd0);
        check({tag, " MOSI"}, 64'(MOSI), 64'd0);
        check({tag, " WRD"}, 64'(wr_if.WRD), 64'd0);
        check({tag, " WRAddr"}, 64'(wr_if.WRAddr), 64'd0);
        check({tag, " WRvalid"}, 64'(wr_if.WRvalid), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [23:0] base_a, base_b;
        RES = 1'b1;
        start = 1'b0;
        BaseAddr = '0;
        wr_if.WRready = 1'b0;
        repeat (3) @(negedge C25M);
        check_reset_state("por");
        RES = 1'b0;

        // Basic load from IDLE with the known flash pattern.
        run_load("basic", 24'h012000, M_READY, -1, -1, '0);
        check("basic busy after start", 64'(busy0), 64'd1);
        check("basic nFCS fall edge", 64'(ncs_fall_rel), 64'd1);
        check("basic first FCK rise", 64'(first_rise_rel), 64'd4);
        check("basic byte0", 64'(got_d.size() > 0 ? got_d[0] : 8'hxx), 64'hA5);
        check("basic byte3", 64'(got_d.size() > 3 ? got_d[3] : 8'hxx), 64'hFF);
        check_data("basic", 24'h012000);
        check_loads("basic", 83, 99, 115, 131);
        check_end("basic", 133, 134);

        // Backpressure: 40 cycles of WRready low after byte 1 completes.
        base_a = 24'($urandom);
        run_load("bp", base_a, M_BACKPR, -1, -1, '0);
        check_data("bp", base_a);
        check_loads("bp", 83, 99, 140, 156);
        check("bp FCK held high in stall", 64'(fck_low_win), 64'd0);
        check_end("bp", 158, 159);

        // Same-edge accept: ready only on byte-complete cycles, no stall.
        base_a = 24'($urandom);
        run_load("same", base_a, M_SAME, -1, -1, '0);
        check_data("same", base_a);
        check_loads("same", 83, 99, 115, 131);
        check_end("same", 133, 148);

        // Reset while byte 2 is being shifted in, then reload.
        base_a = 24'($urandom);
        run_load("rst", base_a, M_READY, 106, -1, '0);
        check("rst loads before reset", 64'(load_rel.size()), 64'd2);
        @(negedge C25M);
        check_reset_state("mid reset");
        RES = 1'b0;
        run_load("reload", base_a, M_READY, -1, -1, '0);
        check_data("reload", base_a);
        check_loads("reload", 83, 99, 115, 131);

        // Start during CMD is ignored; start in DONE reloads the new address.
        base_a = 24'($urandom);
        base_b = base_a ^ 24'h5A5A5A;
        run_load("busy start", base_a, M_READY, -1, 20, base_b);
        check_data("busy start", base_a);
        check_loads("busy start", 83, 99, 115, 131);
        check("busy start done held", 64'(done), 64'd1);
        run_load("restart", base_b, M_READY, -1, -1, '0);
        check("restart done cleared", 64'(done0), 64'd0);
        check("restart busy", 64'(busy0), 64'd1);
        check_data("restart", base_b);

        // Random backpressure against the flash reference.
        for (int t = 0; t < 3; t++) begin
            base_a = 24'($urandom);
            run_load($sformatf("rand%0d", t), base_a, M_RAND, -1, -1, '0);
            check_data($sformatf("rand%0d", t), base_a);
            check($sformatf("rand%0d first load", t), 64'(load_rel.size() > 0 ? load_rel[0] : -1), 64'd83);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
